// File: rtl/rc_pkg.sv
// Shared types and defaults for the reload counter family.
// Step direction decoding used by the top-level step decoder.
package rc_pkg;

    localparam int RC_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN
    } step_e;

    // Opposing requests cancel; only an unambiguous request produces a step.
    function automatic step_e decode_step(input logic inc, input logic dec);
        step_e dir;
        dir = STEP_NONE;
        if (inc && !dec) begin
            dir = STEP_UP;
        end else if (dec && !inc) begin
            dir = STEP_DOWN;
        end
        return dir;
    endfunction

endpackage

// File: rtl/rc_prescaler.sv
// Prescaler: emits tick once every PRESCALE cycles of continuous run.
// Latency: tick is combinational from run and the registered phase count.
// Backpressure: none; dropping run or asserting clear restarts the phase at 0.
module rc_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clock, reset_n, clear};
            assign tick = run;
        end else begin : g_count
            localparam int CW = $clog2(PRESCALE);
            localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

            logic [CW-1:0] phase;

            always_ff @(posedge clock) begin
                if (!reset_n || clear || !run) begin
                    phase <= '0;
                end else if (phase == LAST) begin
                    phase <= '0;
                end else begin
                    phase <= phase + 1'b1;
                end
            end

            assign tick = run && (phase == LAST);
        end
    endgenerate

endmodule

// File: rtl/reload_counter.sv
// Loadable up/down timer counter with reload register, wrap/saturate and tc/ovf pulses.
// Latency: count/tc/ovf update one edge after latch or step; zero decodes the count register.
// Backpressure: none; held inc/dec advance through the prescaler, latch and reset take priority.
module reload_counter
    import rc_pkg::*;
#(
    parameter int WIDTH    = RC_WIDTH_DEFAULT,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             latch,
    input  logic             dec,
    input  logic             inc,
    input  logic             auto_reload,
    input  logic             saturate,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    step_e            step_dir;
    logic             step_req;
    logic             tick;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;

    assign step_dir = decode_step(inc, dec);
    assign step_req = (step_dir != STEP_NONE);

    rc_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (latch),
        .run    (step_req),
        .tick   (tick)
    );

    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        ovf_nxt   = 1'b0;
        if (tick) begin
            case (step_dir)
                STEP_DOWN: begin
                    if (count == '0) begin
                        // Periodic mode reloads and flags tc even when reload is 0.
                        if (auto_reload) begin
                            count_nxt = reload;
                            tc_nxt    = 1'b1;
                        end else if (!saturate) begin
                            count_nxt = MAX;
                        end
                    end else begin
                        count_nxt = count - ONE;
                        tc_nxt    = (count == ONE);
                    end
                end
                STEP_UP: begin
                    if (count == MAX) begin
                        if (!saturate) begin
                            count_nxt = '0;
                            ovf_nxt   = 1'b1;
                        end
                    end else begin
                        count_nxt = count + ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count  <= '0;
            reload <= '0;
            tc     <= 1'b0;
            ovf    <= 1'b0;
        end else if (latch) begin
            count  <= in;
            reload <= in;
            tc     <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            count  <= count_nxt;
            tc     <= tc_nxt;
            ovf    <= ovf_nxt;
        end
    end

    assign zero = (count == '0);

endmodule

// File: tb/tb_reload_counter.sv
// Vector table for a PRESCALE=1 and a PRESCALE=4 counter; expectations are queued when
// each vector is driven and popped for comparison one edge later.
module tb_reload_counter;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    // DUT A: PRESCALE=1
    logic       a_rst_n, a_latch, a_inc, a_dec, a_ar, a_sat;
    logic [3:0] a_in, a_count;
    logic       a_zero, a_tc, a_ovf;
    // DUT B: PRESCALE=4
    logic       b_rst_n, b_latch, b_inc, b_dec, b_ar, b_sat;
    logic [3:0] b_in, b_count;
    logic       b_zero, b_tc, b_ovf;

    reload_counter #(.WIDTH(4), .PRESCALE(1)) dut_a (
        .clock(clock), .reset_n(a_rst_n), .in(a_in), .latch(a_latch), .dec(a_dec),
        .inc(a_inc), .auto_reload(a_ar), .saturate(a_sat),
        .count(a_count), .zero(a_zero), .tc(a_tc), .ovf(a_ovf)
    );

    reload_counter #(.WIDTH(4), .PRESCALE(4)) dut_b (
        .clock(clock), .reset_n(b_rst_n), .in(b_in), .latch(b_latch), .dec(b_dec),
        .inc(b_inc), .auto_reload(b_ar), .saturate(b_sat),
        .count(b_count), .zero(b_zero), .tc(b_tc), .ovf(b_ovf)
    );

    typedef struct {
        logic       dut_b;
        logic       rst_n;
        logic       latch;
        logic [3:0] in;
        logic       inc;
        logic       dec;
        logic       ar;
        logic       sat;
        logic [3:0] e_count;
        logic       e_zero;
        logic       e_tc;
        logic       e_ovf;
        string      name;
    } vec_t;

    typedef struct {
        logic       dut_b;
        logic [3:0] e_count;
        logic       e_zero;
        logic       e_tc;
        logic       e_ovf;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic b, input logic r, input logic l, input logic [3:0] i,
                                input logic up, input logic dn, input logic ar, input logic sat,
                                input logic [3:0] ec, input logic ez, input logic et,
                                input logic eo, input string nm);
        vec_t v;
        v.dut_b = b;  v.rst_n = r;  v.latch = l;  v.in = i;
        v.inc = up;   v.dec = dn;   v.ar = ar;    v.sat = sat;
        v.e_count = ec; v.e_zero = ez; v.e_tc = et; v.e_ovf = eo; v.name = nm;
        return v;
    endfunction

    task automatic chk(input string nm, input string field, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, field, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        logic [3:0] c;
        logic z, t, o;
        // Selected DUT gets the vector, the other one idles and keeps its state.
        a_rst_n = 1'b1; a_latch = 1'b0; a_inc = 1'b0; a_dec = 1'b0;
        b_rst_n = 1'b1; b_latch = 1'b0; b_inc = 1'b0; b_dec = 1'b0;
        if (v.dut_b) begin
            b_rst_n = v.rst_n; b_latch = v.latch; b_in = v.in;
            b_inc = v.inc; b_dec = v.dec; b_ar = v.ar; b_sat = v.sat;
        end else begin
            a_rst_n = v.rst_n; a_latch = v.latch; a_in = v.in;
            a_inc = v.inc; a_dec = v.dec; a_ar = v.ar; a_sat = v.sat;
        end
        e.dut_b = v.dut_b; e.e_count = v.e_count; e.e_zero = v.e_zero;
        e.e_tc = v.e_tc; e.e_ovf = v.e_ovf; e.name = v.name;
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        if (got.dut_b) begin
            c = b_count; z = b_zero; t = b_tc; o = b_ovf;
        end else begin
            c = a_count; z = a_zero; t = a_tc; o = a_ovf;
        end
        chk(got.name, "count", int'(c), int'(got.e_count));
        chk(got.name, "zero",  int'(z), int'(got.e_zero));
        chk(got.name, "tc",    int'(t), int'(got.e_tc));
        chk(got.name, "ovf",   int'(o), int'(got.e_ovf));
    endtask

    initial begin
        a_rst_n = 1'b0; a_latch = 1'b0; a_in = '0; a_inc = 1'b0; a_dec = 1'b0; a_ar = 1'b0; a_sat = 1'b0;
        b_rst_n = 1'b0; b_latch = 1'b0; b_in = '0; b_inc = 1'b0; b_dec = 1'b0; b_ar = 1'b0; b_sat = 1'b0;

        //          B  rst lat in  inc dec ar sat  cnt z tc ovf
        vecs.push_back(mk(0, 0, 0, 4'd9, 1, 0, 0, 0,  4'd0,  1, 0, 0, "reset_a"));
        // latch 2, count down saturating
        vecs.push_back(mk(0, 1, 1, 4'd2, 0, 0, 0, 1,  4'd2,  0, 0, 0, "t1_latch"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 0, 1,  4'd1,  0, 0, 0, "t1_dec1"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 0, 1,  4'd0,  1, 1, 0, "t1_dec2"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 0, 1,  4'd0,  1, 0, 0, "t1_hold0"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 0, 1,  4'd0,  1, 0, 0, "t1_hold1"));
        // wrap down from 0, cancelling requests, wrap up
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 0, 0,  4'd15, 0, 0, 0, "t4_wrapdn"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 1, 0, 0,  4'd15, 0, 0, 0, "t4_both"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 0, 0, 0,  4'd0,  1, 0, 1, "t4_wrapup"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 0, 0,  4'd0,  1, 0, 0, "t4_idle"));
        // increment wrap vs saturate
        vecs.push_back(mk(0, 1, 1, 4'd14, 0, 0, 0, 0, 4'd14, 0, 0, 0, "t3_latch"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 0, 0, 0,  4'd15, 0, 0, 0, "t3_inc15"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 0, 0, 0,  4'd0,  1, 0, 1, "t3_ovf"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 0, 0, 0,  4'd1,  0, 0, 0, "t3_post"));
        vecs.push_back(mk(0, 1, 1, 4'd14, 0, 0, 0, 1, 4'd14, 0, 0, 0, "t3s_latch"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 0, 0, 1,  4'd15, 0, 0, 0, "t3s_inc"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 0, 0, 1,  4'd15, 0, 0, 0, "t3s_hold0"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 0, 1, 1,  4'd15, 0, 0, 0, "t3s_hold1"));
        // auto-reload period 4
        vecs.push_back(mk(0, 1, 1, 4'd3, 0, 0, 1, 0,  4'd3,  0, 0, 0, "t2_latch"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 1, 0,  4'd2,  0, 0, 0, "t2_d1"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 1, 0,  4'd1,  0, 0, 0, "t2_d2"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 1, 0,  4'd0,  1, 1, 0, "t2_d3"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 1, 0,  4'd3,  0, 1, 0, "t2_d4"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 1, 0,  4'd2,  0, 0, 0, "t2_d5"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 1, 0,  4'd1,  0, 0, 0, "t2_d6"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 1, 0,  4'd0,  1, 1, 0, "t2_d7"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 1, 0,  4'd3,  0, 1, 0, "t2_d8"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 1, 0,  4'd3,  0, 0, 0, "t2_idle"));
        // reload of zero pulses tc on every step
        vecs.push_back(mk(0, 1, 1, 4'd0, 0, 0, 1, 0,  4'd0,  1, 0, 0, "r0_latch"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 1, 0,  4'd0,  1, 1, 0, "r0_d1"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 1, 0,  4'd0,  1, 1, 0, "r0_d2"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 1, 0,  4'd0,  1, 0, 0, "r0_idle"));
        // latch beats step and suppresses tc
        vecs.push_back(mk(0, 1, 1, 4'd5, 0, 1, 0, 1,  4'd5,  0, 0, 0, "t6_latchdec"));
        vecs.push_back(mk(0, 1, 1, 4'd1, 0, 0, 1, 1,  4'd1,  0, 0, 0, "t6_latch1"));
        vecs.push_back(mk(0, 1, 1, 4'd7, 0, 1, 1, 1,  4'd7,  0, 0, 0, "t6_notc"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 1, 1, 1,  4'd6,  0, 0, 0, "t6_dec"));
        // reset beats step and suppresses pulses
        vecs.push_back(mk(0, 1, 1, 4'd1, 0, 0, 0, 1,  4'd1,  0, 0, 0, "rst_latch1"));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 0, 1,  4'd0,  1, 0, 0, "rst_dec"));
        vecs.push_back(mk(0, 1, 1, 4'd15, 0, 0, 0, 0, 4'd15, 0, 0, 0, "rst_latch15"));
        vecs.push_back(mk(0, 0, 1, 4'd6, 1, 0, 0, 0,  4'd0,  1, 0, 0, "rst_inc"));
        vecs.push_back(mk(0, 1, 0, 4'd0, 0, 0, 0, 0,  4'd0,  1, 0, 0, "rst_idle"));
        // PRESCALE=4: one step per four held cycles, gap restarts phase
        vecs.push_back(mk(1, 0, 0, 4'd0, 0, 0, 0, 1,  4'd0,  1, 0, 0, "reset_b"));
        vecs.push_back(mk(1, 1, 1, 4'd2, 0, 0, 0, 1,  4'd2,  0, 0, 0, "p_latch"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 1,  4'd2,  0, 0, 0, "p_e1"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 1,  4'd2,  0, 0, 0, "p_e2"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 1,  4'd2,  0, 0, 0, "p_e3"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 1,  4'd1,  0, 0, 0, "p_e4"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 1,  4'd1,  0, 0, 0, "p_e5"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 1,  4'd1,  0, 0, 0, "p_e6"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 0, 0, 1,  4'd1,  0, 0, 0, "p_gap"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 1,  4'd1,  0, 0, 0, "p_r1"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 1,  4'd1,  0, 0, 0, "p_r2"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 1,  4'd1,  0, 0, 0, "p_r3"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 1,  4'd0,  1, 1, 0, "p_r4"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 0, 0, 1,  4'd0,  1, 0, 0, "p_idle"));
        // PRESCALE=4: reset during a prescaler run restarts the phase
        vecs.push_back(mk(1, 1, 1, 4'd3, 0, 0, 0, 0,  4'd3,  0, 0, 0, "pr_latch"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 0,  4'd3,  0, 0, 0, "pr_e1"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 0,  4'd3,  0, 0, 0, "pr_e2"));
        vecs.push_back(mk(1, 0, 0, 4'd0, 0, 1, 0, 0,  4'd0,  1, 0, 0, "pr_rst"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 0,  4'd0,  1, 0, 0, "pr_a1"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 0,  4'd0,  1, 0, 0, "pr_a2"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 0,  4'd0,  1, 0, 0, "pr_a3"));
        vecs.push_back(mk(1, 1, 0, 4'd0, 0, 1, 0, 0,  4'd15, 0, 0, 0, "pr_a4"));

        @(posedge clock);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
